sid_sample_capture: RTL and testbench

//  Synthesisable, parametrised successor to the bench-side decimating sample capture.

---
 rtl/sid_cap_pkg.sv | 20 ++
 rtl/sid_cap_fifo.sv | 65 ++++++
 rtl/sid_sample_capture.sv | 175 +++++++++++++++++
 tb/tb_sid_sample_capture.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_cap_pkg.sv
// Shared definitions for the SID sample-capture block.
//   cap_state_e : capture FSM state encoding (also the value seen on dbg_state)
//   DEF_*       : default parameter values for the capture top
package sid_cap_pkg;

  localparam int DEF_NCH      = 2;
  localparam int DEF_DW       = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_DECIM_W  = 12;
  localparam int DEF_SETTLE_W = 20;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sid_cap_fifo.sv
// Synchronous frame FIFO, DEPTH entries of W bits.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : synchronous clear of contents (wins over push/pop)
//   push        : write push_data; ignored when full unless a pop happens in the same cycle
//   push_data   : frame to store
//   pop         : consumer accepts head; ignored when empty
//   rd_data     : head frame, 0 when empty
//   level       : number of stored frames
//   full, empty : occupancy flags
// Handshake: a frame moves out on any cycle where !empty && pop (valid && ready).
module sid_cap_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sid_sample_capture.sv
// Decimating capture of NCH audio channels into a frame FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   cfg_*       : run configuration, latched on an accepted start
//   start       : begin a run (only from IDLE or DONE)
//   abort       : return to IDLE and flush the FIFO (wins over start)
//   ch_in       : channel samples, channel k at [k*DW +: DW]
//   rd_ready    : consumer ready; rd_valid/rd_ready is a plain valid/ready pair,
//                 a frame transfers on every cycle where both are high
//   rd_valid    : FIFO non-empty
//   rd_data     : head frame, same packing as ch_in
//   busy, done  : SETTLE/CAPTURE, DONE
//   overflow    : sticky, a frame was dropped since the last start
//   level       : frames in FIFO
//   dbg_state   : current FSM state (cap_state_e encoding)
module sid_sample_capture
  import sid_cap_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int DECIM_W  = DEF_DECIM_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DECIM_W-1:0]              cfg_decim,
  input  logic [SETTLE_W-1:0]             cfg_settle,
  input  logic [CNT_W-1:0]                cfg_count,
  input  logic                            cfg_avg,
  input  logic [$clog2(DECIM_W+DW)-1:0]   cfg_shift,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NCH*DW-1:0]               ch_in,
  input  logic                            rd_ready,
  output logic                            rd_valid,
  output logic [NCH*DW-1:0]               rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [$clog2(DEPTH+1)-1:0]      level,
  output logic [1:0]                      dbg_state
);

  // DW+DECIM_W bits hold the sum of up to 2^DECIM_W-1 full-scale samples.
  localparam int ACC_W = DW + DECIM_W;
  localparam int SH_W  = $clog2(DECIM_W + DW);

  cap_state_e                  state;
  logic [DECIM_W-1:0]          decim_sh;
  logic [DECIM_W-1:0]          win_cnt;
  logic [SETTLE_W-1:0]         settle_sh;
  logic [SETTLE_W-1:0]         settle_cnt;
  logic [CNT_W-1:0]            count_sh;
  logic [CNT_W-1:0]            frames;
  logic [CNT_W-1:0]            frames_inc;
  logic                        avg_sh;
  logic [SH_W-1:0]             shift_sh;
  logic [NCH-1:0][ACC_W-1:0]   acc;
  logic [NCH-1:0][ACC_W-1:0]   acc_nxt;
  logic [NCH-1:0][DW-1:0]      pt_q;
  logic [NCH-1:0][DW-1:0]      frame;
  logic [ACC_W-1:0]            shifted;
  logic                        start_ok;
  logic                        win_first;
  logic                        win_last;
  logic                        push;
  logic                        fifo_full;
  logic                        fifo_empty;

  assign start_ok   = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign win_first  = (win_cnt == '0);
  assign win_last   = (win_cnt == decim_sh - DECIM_W'(1));
  assign push       = (state == ST_CAPTURE) && win_last && !abort;
  assign frames_inc = frames + CNT_W'(1);

  assign busy      = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign rd_valid  = !fifo_empty;
  assign dbg_state = state;

  // Frame assembly works on the current cycle's sample too, so a D=1 window
  // (first == last) and the final add of an average window need no extra cycle.
  always_comb begin
    acc_nxt = '0;
    frame   = '0;
    shifted = '0;
    for (int k = 0; k < NCH; k++) begin
      acc_nxt[k] = (win_first ? '0 : acc[k]) + ACC_W'(ch_in[k*DW +: DW]);
      shifted    = acc_nxt[k] >> shift_sh;
      if (avg_sh) begin
        frame[k] = (|shifted[ACC_W-1:DW]) ? {DW{1'b1}} : shifted[DW-1:0];
      end else begin
        frame[k] = win_first ? ch_in[k*DW +: DW] : pt_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      decim_sh   <= '0;
      settle_sh  <= '0;
      count_sh   <= '0;
      avg_sh     <= 1'b0;
      shift_sh   <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      frames     <= '0;
      overflow   <= 1'b0;
      acc        <= '0;
      pt_q       <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            decim_sh   <= (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
            settle_sh  <= cfg_settle;
            count_sh   <= cfg_count;
            avg_sh     <= cfg_avg;
            shift_sh   <= cfg_shift;
            settle_cnt <= '0;
            win_cnt    <= '0;
            frames     <= '0;
            overflow   <= 1'b0;
            state      <= (cfg_settle == '0) ? ST_CAPTURE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == settle_sh - SETTLE_W'(1)) begin
            win_cnt <= '0;
            state   <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        ST_CAPTURE: begin
          acc <= acc_nxt;
          if (win_first) pt_q <= ch_in;
          if (win_last) begin
            win_cnt <= '0;
            // Dropped frames still count toward cfg_count.
            frames  <= frames_inc;
            if (fifo_full && !rd_ready) overflow <= 1'b1;
            if (count_sh != '0 && frames_inc == count_sh) state <= ST_DONE;
          end else begin
            win_cnt <= win_cnt + DECIM_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sid_cap_fifo #(
    .W     (NCH*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_ok || abort),
    .push      (push),
    .push_data (frame),
    .pop       (rd_ready),
    .rd_data   (rd_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sid_sample_capture.sv
module tb_sid_sample_capture;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int FW  = NCH * DW;

  logic            clk;
  logic            rst;
  logic [11:0]     cfg_decim;
  logic [19:0]     cfg_settle;
  logic [15:0]     cfg_count;
  logic            cfg_avg;
  logic [4:0]      cfg_shift;
  logic            start;
  logic            abort;
  logic [FW-1:0]   ch_in;
  logic            rd_ready;
  logic            rd_valid;
  logic [FW-1:0]   rd_data;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [4:0]      level;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  logic [FW-1:0] exp_q[$];

  sid_sample_capture dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_decim  (cfg_decim),
    .cfg_settle (cfg_settle),
    .cfg_count  (cfg_count),
    .cfg_avg    (cfg_avg),
    .cfg_shift  (cfg_shift),
    .start      (start),
    .abort      (abort),
    .ch_in      (ch_in),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .level      (level),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int d, input int s, input int c, input logic a, input int sh);
    cfg_decim  = 12'(d);
    cfg_settle = 20'(s);
    cfg_count  = 16'(c);
    cfg_avg    = a;
    cfg_shift  = 5'(sh);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    check("drained", 32'(exp_q.size()), 0);
  endtask

  // scoreboard: every accepted frame is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      pop_cnt++;
      check("frame_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("frame", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int busy_cnt;
    int first_valid;
    logic [7:0] c1;

    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; ch_in = '0;
    configure(1, 0, 0, 1'b0, 0);
    repeat (3) tick();
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick();

    // 1: point mode, D=4, ramp; frames hold window-start samples 0,4,8
    configure(4, 0, 3, 1'b0, 0);
    rd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      c1 = 8'($urandom_range(0, 255));
      ch_in = {c1, 8'(i)};
      if (i % 4 == 0) exp_q.push_back(ch_in);
      @(negedge clk);
      check("t1_busy", 32'(busy), 1);
      check("t1_not_done", 32'(done), 0);
      tick();
    end
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_idle_busy", 32'(busy), 0);
    drain(4);

    // 2: settle 10, D=1, count 2; mid-run config changes ignored
    configure(1, 10, 2, 1'b0, 0);
    rd_ready = 1'b0;
    ch_in = 16'h5AA5;
    exp_q.push_back(16'h5AA5);
    exp_q.push_back(16'h5AA5);
    pulse_start();
    cfg_decim = 12'd7;
    cfg_count = 16'd5;
    busy_cnt = 0;
    first_valid = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (rd_valid && first_valid == 0) first_valid = n;
      tick();
    end
    check("t2_busy_cycles", 32'(busy_cnt), 12);
    check("t2_first_valid", 32'(first_valid), 12);
    check("t2_level", 32'(level), 2);
    check("t2_done", 32'(done), 1);
    drain(4);

    // 3: average mode, D=4, shift=2: (10+20+30+40)>>2 = 25, (4*200)>>2 = 200
    configure(4, 0, 2, 1'b1, 2);
    rd_ready = 1'b1;
    exp_q.push_back({8'd200, 8'd25});
    exp_q.push_back({8'd200, 8'd25});
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      ch_in = {8'd200, 8'(10 * (i % 4 + 1))};
      tick();
    end
    @(negedge clk);
    check("t3_done", 32'(done), 1);
    drain(4);

    // 3b: shift=0, full-scale sum saturates; small sum passes through
    configure(4, 0, 1, 1'b1, 0);
    exp_q.push_back({8'd12, 8'd255});
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ch_in = {8'd3, 8'd255};
      tick();
    end
    drain(4);

    // 4: no consumer, 20 frames into 16 entries
    configure(1, 0, 20, 1'b0, 0);
    rd_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      ch_in = {~8'(k), 8'(k)};
      if (k < 16) exp_q.push_back(ch_in);
      tick();
    end
    @(negedge clk);
    check("t4_level", 32'(level), 16);
    check("t4_ovf", 32'(overflow), 1);
    check("t4_done", 32'(done), 1);
    pop_cnt = 0;
    drain(24);
    check("t4_drain_cnt", 32'(pop_cnt), 16);
    check("t4_level_empty", 32'(level), 0);

    // 5: full FIFO with push and pop together never drops
    configure(1, 0, 20, 1'b0, 0);
    rd_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      ch_in = {8'(k + 50), 8'(k)};
      exp_q.push_back(ch_in);
      if (k == 16) rd_ready = 1'b1;
      tick();
    end
    @(negedge clk);
    check("t5_level", 32'(level), 16);
    check("t5_ovf", 32'(overflow), 0);
    drain(24);

    // 6: abort mid-capture with 3 frames buffered
    configure(1, 0, 0, 1'b0, 0);
    rd_ready = 1'b0;
    ch_in = 16'h1234;
    pulse_start();
    repeat (3) tick();
    @(negedge clk);
    check("t6_level_pre", 32'(level), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("t6_state", 32'(dbg_state), 0);
    check("t6_level", 32'(level), 0);
    check("t6_valid", 32'(rd_valid), 0);
    check("t6_busy", 32'(busy), 0);

    // 6b: start while busy ignored, then reset mid-settle
    configure(1, 100, 1, 1'b0, 0);
    pulse_start();
    repeat (4) tick();
    pulse_start();
    @(negedge clk);
    check("t6b_settle", 32'(dbg_state), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6b_state", 32'(dbg_state), 0);
    check("t6b_busy", 32'(busy), 0);
    check("t6b_level", 32'(level), 0);

    // abort beats start in the same cycle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wins", 32'(dbg_state), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
